// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream to 32-bit word loader for the instruction memory
//
// Purpose:
//   Receives a framed byte stream and writes it into the word-addressed
//   instruction memory. Each word is packed little-endian. The CPU core is
//   held in reset until the whole image has been written.
//   Frame: 16-bit word count N (low byte first), then 4*N data bytes.
//
// Optional feature (macro IMEM_LOADER_CHECKSUM_EN):
//   When defined, one trailing byte must equal the XOR of all data bytes.
//   A match ends the load in DONE and a mismatch ends it in ERR.
//
// Ports:
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   start         one-cycle pulse that begins a load (ignored while busy)
//   in_valid      byte stream valid
//   in_data       byte stream data
//   in_ready      loader can accept a byte
//   we            imem write enable, one-cycle pulse per word
//   wa            imem word address
//   wd            imem write data
//   busy          load in progress
//   done          image loaded successfully (level)
//   err           load failed (level)
//   cpu_reset     active-high reset to the CPU core
//   words_loaded  number of words written during this load

module imem_loader #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] wa,
    output logic [DATA_W-1:0] wd,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_reset,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR_LO = 3'd1,
        S_HDR_HI = 3'd2,
        S_DATA   = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        S_CHK    = 3'd6
`endif
    } state_t;

    // Largest legal word count: the full memory.
    localparam logic [16:0]   CAPACITY = 17'(1) << ADDR_W;
    localparam logic [ADDR_W:0] ONE    = {{ADDR_W{1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [7:0]          n_lo_q, n_lo_d;
    logic [ADDR_W:0]     n_q, n_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [23:0]         sh_q, sh_d;
    logic [ADDR_W-1:0]   wa_q, wa_d;
    logic [DATA_W-1:0]   wd_q, wd_d;
    logic                we_q, we_d;
    logic [ADDR_W:0]     wl_q, wl_d;
    logic                cpu_reset_q, cpu_reset_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          chk_q, chk_d;
`endif

    logic        accept;
    logic        load_start;
    logic        last_byte;
    logic [15:0] hdr_n;

    assign accept     = in_valid && in_ready;
    assign load_start = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
    assign hdr_n      = {in_data, n_lo_q};
    // Final byte of the final word: byte 3 of word index N-1.
    assign last_byte  = (byte_cnt_q == 2'd3) && ((wl_q + ONE) == n_q);

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            n_lo_q      <= '0;
            n_q         <= '0;
            byte_cnt_q  <= '0;
            sh_q        <= '0;
            wa_q        <= '0;
            wd_q        <= '0;
            we_q        <= 1'b0;
            wl_q        <= '0;
            cpu_reset_q <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            n_lo_q      <= n_lo_d;
            n_q         <= n_d;
            byte_cnt_q  <= byte_cnt_d;
            sh_q        <= sh_d;
            wa_q        <= wa_d;
            wd_q        <= wd_d;
            we_q        <= we_d;
            wl_q        <= wl_d;
            cpu_reset_q <= cpu_reset_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q       <= chk_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_d = S_HDR_LO;
            end
            S_HDR_LO: begin
                if (accept) state_d = S_HDR_HI;
            end
            S_HDR_HI: begin
                if (accept) begin
                    if (hdr_n == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_DONE;
`endif
                    end else if ({1'b0, hdr_n} > CAPACITY) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept && last_byte) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept) state_d = (in_data == chk_q) ? S_DONE : S_ERR;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        n_lo_d      = n_lo_q;
        n_d         = n_q;
        byte_cnt_d  = byte_cnt_q;
        sh_d        = sh_q;
        wa_d        = wa_q;
        wd_d        = wd_q;
        we_d        = 1'b0;
        wl_d        = wl_q;
        cpu_reset_d = cpu_reset_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk_d       = chk_q;
`endif

        // Release the core one cycle after done rises.
        if (state_q == S_DONE) cpu_reset_d = 1'b0;

        if (load_start) begin
            wa_d        = '0;
            wl_d        = '0;
            byte_cnt_d  = '0;
            cpu_reset_d = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_d       = '0;
`endif
        end

        if (accept && state_q == S_HDR_LO) n_lo_d = in_data;
        // Only the low bits matter: oversized counts are routed to ERR.
        if (accept && state_q == S_HDR_HI) n_d = hdr_n[ADDR_W:0];

        if (accept && state_q == S_DATA) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            // Bytes enter at the top so b0 ends up in the low byte.
            sh_d = {in_data, sh_q[23:8]};
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_d = chk_q ^ in_data;
`endif
            if (byte_cnt_q == 2'd3) begin
                wd_d = {in_data, sh_q};
                wa_d = wl_q[ADDR_W-1:0];
                we_d = 1'b1;
                wl_d = wl_q + ONE;
            end
        end
    end

    // Outputs decoded from state and registers
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            S_HDR_LO, S_HDR_HI, S_DATA: in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK:                      in_ready = 1'b1;
`endif
            default:                    in_ready = 1'b0;
        endcase
        busy         = in_ready;
        done         = (state_q == S_DONE);
        err          = (state_q == S_ERR);
        we           = we_q;
        wa           = wa_q;
        wd           = wd_q;
        cpu_reset    = cpu_reset_q;
        words_loaded = wl_q;
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader

module tb_imem_loader;

    localparam int ADDR_W = 6;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [31:0]       wd;
    logic              busy;
    logic              done;
    logic              err;
    logic              cpu_reset;
    logic [ADDR_W:0]   words_loaded;

    imem_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .we           (we),
        .wa           (wa),
        .wd           (wd),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .cpu_reset    (cpu_reset),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        v;
        logic [7:0]  d;
        logic        rdy;
        logic        we;
        logic [5:0]  wa;
        logic [31:0] wd;
        logic        done;
        logic        err;
        logic        cpu;
        logic [6:0]  wl;
    } vec_t;

    vec_t tbl[$];
    logic [37:0] wr_q[$];
    logic [37:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Record every imem write, sampled away from the active edge.
    always @(negedge clk) begin
        if (reset_n && we) wr_q.push_back({wa, wd});
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t row(input logic st, input logic v, input logic [7:0] d,
                                 input logic rdy, input logic w, input logic [5:0] a,
                                 input logic [31:0] dat, input logic dn, input logic er,
                                 input logic cpu, input logic [6:0] wl);
        vec_t r;
        r.st = st; r.v = v; r.d = d; r.rdy = rdy; r.we = w; r.wa = a; r.wd = dat;
        r.done = dn; r.err = er; r.cpu = cpu; r.wl = wl;
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n  = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wr_q.delete();
        exp_q.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one byte after 'gap' idle cycles and hold it until accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        #1;
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_byte_timeout: in_ready got 0 expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int t;
        t = 0;
        @(negedge clk);
        #1;
        while (!(done || err) && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk({name, "_end"}, 64'(done || err), 64'd1);
    endtask

    // Full frame with generated data; expected writes go to exp_q.
    task automatic send_frame(input int n, input int gapmax);
        logic [7:0]  b;
        logic [7:0]  x;
        logic [31:0] w;
        x = 8'h00;
        pulse_start();
        send_byte(8'(n), 0);
        send_byte(8'(n >> 8), 0);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                b = 8'((i * 4 + k) * 37 + 5);
                w[k*8 +: 8] = b;
                x = x ^ b;
                send_byte(b, (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0);
            end
            exp_q.push_back({6'(i), w});
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(x, 0);
`endif
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Reset values while reset is held
        repeat (2) @(negedge clk);
        #1;
        chk("rst_cpu_reset", 64'(cpu_reset), 64'd1);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_we", 64'(we), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_wa", 64'(wa), 64'd0);
        chk("rst_wd", 64'(wd), 64'd0);
        chk("rst_words", 64'(words_loaded), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Cycle-exact table; each row: inputs driven, then outputs checked before the edge
        tbl.push_back(row(1, 0, 8'h00, 0, 0, 0, 32'h0, 0, 0, 1, 0));
`ifdef IMEM_LOADER_CHECKSUM_EN
        tbl.push_back(row(0, 1, 8'h01, 1, 0, 0, 32'h0, 0, 0, 1, 0));
        tbl.push_back(row(0, 1, 8'h00, 1, 0, 0, 32'h0, 0, 0, 1, 0));
        tbl.push_back(row(0, 1, 8'h01, 1, 0, 0, 32'h0, 0, 0, 1, 0));
        tbl.push_back(row(0, 1, 8'h02, 1, 0, 0, 32'h0, 0, 0, 1, 0));
        tbl.push_back(row(0, 1, 8'h04, 1, 0, 0, 32'h0, 0, 0, 1, 0));
        tbl.push_back(row(0, 1, 8'h08, 1, 0, 0, 32'h0, 0, 0, 1, 0));
        tbl.push_back(row(0, 1, 8'h0f, 1, 1, 0, 32'h08040201, 0, 0, 1, 1));
        tbl.push_back(row(0, 0, 8'h00, 0, 0, 0, 32'h08040201, 1, 0, 1, 1));
        tbl.push_back(row(0, 0, 8'h00, 0, 0, 0, 32'h08040201, 1, 0, 0, 1));
`else
        tbl.push_back(row(0, 1, 8'h02, 1, 0, 0, 32'h0, 0, 0, 1, 0));
        tbl.push_back(row(0, 1, 8'h00, 1, 0, 0, 32'h0, 0, 0, 1, 0));
        tbl.push_back(row(0, 1, 8'h0f, 1, 0, 0, 32'h0, 0, 0, 1, 0));
        tbl.push_back(row(0, 1, 8'h00, 1, 0, 0, 32'h0, 0, 0, 1, 0));
        tbl.push_back(row(0, 1, 8'h4f, 1, 0, 0, 32'h0, 0, 0, 1, 0));
        tbl.push_back(row(0, 1, 8'he0, 1, 0, 0, 32'h0, 0, 0, 1, 0));
        tbl.push_back(row(0, 1, 8'h0f, 1, 1, 0, 32'he04f000f, 0, 0, 1, 1));
        tbl.push_back(row(0, 1, 8'h10, 1, 0, 0, 32'he04f000f, 0, 0, 1, 1));
        tbl.push_back(row(0, 1, 8'h4f, 1, 0, 0, 32'he04f000f, 0, 0, 1, 1));
        tbl.push_back(row(0, 1, 8'he0, 1, 0, 0, 32'he04f000f, 0, 0, 1, 1));
        tbl.push_back(row(0, 0, 8'h00, 0, 1, 1, 32'he04f100f, 1, 0, 1, 2));
        tbl.push_back(row(0, 0, 8'h00, 0, 0, 1, 32'he04f100f, 1, 0, 0, 2));
`endif
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            start    = tbl[i].st;
            in_valid = tbl[i].v;
            in_data  = tbl[i].d;
            #1;
            chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].rdy));
            chk($sformatf("vec%0d_we", i), 64'(we), 64'(tbl[i].we));
            chk($sformatf("vec%0d_wa", i), 64'(wa), 64'(tbl[i].wa));
            chk($sformatf("vec%0d_wd", i), 64'(wd), 64'(tbl[i].wd));
            chk($sformatf("vec%0d_done", i), 64'(done), 64'(tbl[i].done));
            chk($sformatf("vec%0d_err", i), 64'(err), 64'(tbl[i].err));
            chk($sformatf("vec%0d_cpu_reset", i), 64'(cpu_reset), 64'(tbl[i].cpu));
            chk($sformatf("vec%0d_words", i), 64'(words_loaded), 64'(tbl[i].wl));
        end
        start    = 1'b0;
        in_valid = 1'b0;

        // Overflow: N=65 with 64-word capacity
        do_reset();
        pulse_start();
        send_byte(8'h41, 0);
        send_byte(8'h00, 0);
        repeat (2) @(negedge clk);
        #1;
        chk("ovf_err", 64'(err), 64'd1);
        chk("ovf_in_ready", 64'(in_ready), 64'd0);
        chk("ovf_cpu_reset", 64'(cpu_reset), 64'd1);
        chk("ovf_done", 64'(done), 64'd0);
        chk("ovf_writes", 64'(wr_q.size()), 64'd0);

        // Stalls within words plus a start pulse mid-DATA
        do_reset();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h0f, $urandom_range(5, 0));
        send_byte(8'h00, $urandom_range(5, 0));
        send_byte(8'h4f, $urandom_range(5, 0));
        pulse_start();
        send_byte(8'he0, $urandom_range(5, 0));
        send_byte(8'h0f, $urandom_range(5, 0));
        send_byte(8'h10, $urandom_range(5, 0));
        send_byte(8'h4f, $urandom_range(5, 0));
        send_byte(8'he0, $urandom_range(5, 0));
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h10, 0);
`endif
        wait_end("stall");
        chk("stall_done", 64'(done), 64'd1);
        chk("stall_nwrites", 64'(wr_q.size()), 64'd2);
        if (wr_q.size() == 2) begin
            chk("stall_w0", 64'(wr_q[0]), 64'({6'd0, 32'he04f000f}));
            chk("stall_w1", 64'(wr_q[1]), 64'({6'd1, 32'he04f100f}));
        end
        chk("stall_words", 64'(words_loaded), 64'd2);

        // Reload after done
        wr_q.delete();
        pulse_start();
        #1;
        chk("reload_done_clr", 64'(done), 64'd0);
        chk("reload_cpu_reset", 64'(cpu_reset), 64'd1);
        chk("reload_busy", 64'(busy), 64'd1);
        chk("reload_words_clr", 64'(words_loaded), 64'd0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'ha4, 0);
        send_byte(8'ha3, 1);
        send_byte(8'ha2, 0);
        send_byte(8'ha1, 2);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h04, 0);
`endif
        wait_end("reload");
        chk("reload_done", 64'(done), 64'd1);
        chk("reload_nwrites", 64'(wr_q.size()), 64'd1);
        if (wr_q.size() == 1) chk("reload_w0", 64'(wr_q[0]), 64'({6'd0, 32'ha1a2a3a4}));

        // Full capacity: N = 64, last write at wa = 63
        do_reset();
        send_frame(64, 1);
        wait_end("full");
        repeat (3) @(negedge clk);
        #1;
        chk("full_done", 64'(done), 64'd1);
        chk("full_words", 64'(words_loaded), 64'd64);
        chk("full_nwrites", 64'(wr_q.size()), 64'd64);
        if (wr_q.size() == 64) begin
            chk("full_first", 64'(wr_q[0]), 64'(exp_q[0]));
            chk("full_last", 64'(wr_q[63]), 64'(exp_q[63]));
        end
        chk("full_cpu_reset", 64'(cpu_reset), 64'd0);

        // Empty image: N = 0
        do_reset();
        send_frame(0, 0);
        wait_end("empty");
        chk("empty_done", 64'(done), 64'd1);
        chk("empty_err", 64'(err), 64'd0);
        chk("empty_nwrites", 64'(wr_q.size()), 64'd0);
        chk("empty_words", 64'(words_loaded), 64'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Bad checksum: final write still happens, load ends in ERR
        do_reset();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h04, 0);
        send_byte(8'h08, 0);
        send_byte(8'h00, 0);
        wait_end("badchk");
        chk("badchk_err", 64'(err), 64'd1);
        chk("badchk_done", 64'(done), 64'd0);
        chk("badchk_cpu_reset", 64'(cpu_reset), 64'd1);
        chk("badchk_nwrites", 64'(wr_q.size()), 64'd1);
`endif

        // Asynchronous reset in the middle of DATA
        do_reset();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        send_byte(8'h55, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_cpu_reset", 64'(cpu_reset), 64'd1);
        chk("midrst_wa", 64'(wa), 64'd0);
        chk("midrst_wd", 64'(wd), 64'd0);
        chk("midrst_words", 64'(words_loaded), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("midrst_idle_ready", 64'(in_ready), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
